fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 67 ++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-entry instruction fetch buffer with valid/ready handoff and redirect.
// Optional macro FETCH_HALT_ON_ZERO_EN: a fetched 16'h0000 enters HALTED instead of issuing.
module fetch_unit #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  input  logic [15:0]           pm_data,
  output logic [15:0]           instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  halted
);

  typedef enum logic [1:0] {EMPTY, FULL, HALTED} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [15:0]           instr_q;
  logic                  valid_q;
  logic                  fetch;
  logic                  zero_halt;

  // A slot is free to refill when empty, or when the held word is consumed this cycle.
  assign fetch = (state_q == EMPTY) || ((state_q == FULL) && instr_ready);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_halt = (pm_data == '0);
  assign halted    = (state_q == HALTED);
`else
  assign zero_halt = 1'b0;
  assign halted    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (redirect) begin
      pc_q    <= redirect_addr;
      valid_q <= 1'b0;
      state_q <= EMPTY;
    end else if (fetch) begin
      if (zero_halt) begin
        valid_q <= 1'b0;
        state_q <= HALTED;
      end else begin
        instr_q <= pm_data;
        pc_q    <= pc_q + ADDR_WIDTH'(1);
        valid_q <= 1'b1;
        state_q <= FULL;
      end
    end
  end

  assign pm_addr     = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_fetch_unit;

  localparam int AW    = 6;
  localparam int DEPTH = 1 << AW;
`ifdef FETCH_HALT_ON_ZERO_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_data;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] pc;
  logic          halted;

  logic [15:0] pm [DEPTH];
  assign pm_data = pm[pm_addr];

  fetch_unit #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .pm_addr(pm_addr), .pm_data(pm_data),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_addr(redirect_addr), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what decode should observe after each edge.
  int unsigned m_pc;
  logic [15:0] m_instr;
  bit          m_valid;
  bit          m_halted;

  task automatic model_reset();
    m_pc = 0; m_instr = '0; m_valid = 0; m_halted = 0;
  endtask

  task automatic model_edge();
    logic [15:0] w;
    if (redirect) begin
      m_pc = int'(redirect_addr); m_valid = 0; m_halted = 0;
    end else if (!m_halted && (!m_valid || instr_ready)) begin
      w = pm[m_pc];
      if (HALT_EN && w == 16'h0000) begin
        m_halted = 1; m_valid = 0;
      end else begin
        m_instr = w; m_valid = 1; m_pc = (m_pc + 1) % DEPTH;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] ei, input bit ev,
                          input int unsigned ep, input bit eh);
    chk({tag, ".instr"},  32'(instr),       32'(ei));
    chk({tag, ".valid"},  32'(instr_valid), 32'(ev));
    chk({tag, ".pc"},     32'(pc),          ep);
    chk({tag, ".halted"}, 32'(halted),      32'(eh));
    chk({tag, ".pm_addr"},32'(pm_addr),     ep);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          ready;
    bit          redir;
    int unsigned raddr;
    logic [15:0] e_instr;
    bit          e_valid;
    int unsigned e_pc;
  } vec_t;

  vec_t vt [$];

  initial begin
    for (int i = 0; i < DEPTH; i++) pm[i] = 16'($urandom_range(1, 16'hFFFF));
    pm[0] = 16'hB203; pm[1] = 16'hB305; pm[40] = 16'h0000;

    instr_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    rst_n = 1'b0; model_reset();
    #3;
    chk_outs("reset", 16'h0000, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1;

    // {ready, redirect, raddr} applied before the edge; outputs expected after it.
    vt.push_back('{1, 0, 0,  16'hB203, 1, 1});
    vt.push_back('{1, 0, 0,  16'hB305, 1, 2});
    vt.push_back('{0, 0, 0,  16'hB305, 1, 2});
    vt.push_back('{0, 0, 0,  16'hB305, 1, 2});
    vt.push_back('{0, 0, 0,  16'hB305, 1, 2});
    vt.push_back('{1, 0, 0,  pm[2],    1, 3});
    vt.push_back('{1, 1, 30, pm[2],    0, 30});
    vt.push_back('{1, 0, 0,  pm[30],   1, 31});
    vt.push_back('{0, 1, 63, pm[30],   0, 63});
    vt.push_back('{1, 0, 0,  pm[63],   1, 0});
    vt.push_back('{1, 0, 0,  16'hB203, 1, 1});
    foreach (vt[i]) begin
      instr_ready = vt[i].ready; redirect = vt[i].redir; redirect_addr = AW'(vt[i].raddr);
      step();
      chk_outs($sformatf("vec%0d", i), vt[i].e_instr, vt[i].e_valid, vt[i].e_pc, 0);
    end
    redirect = 1'b0;

    // Asynchronous reset mid-stall must clear outputs before any clock edge.
    instr_ready = 1'b0; step();
    #2 rst_n = 1'b0; model_reset();
    #1 chk_outs("async_rst", 16'h0000, 0, 0, 0);
    @(negedge clk); rst_n = 1'b1; instr_ready = 1'b1;
    step(); chk_outs("post_rst", 16'hB203, 1, 1, 0);

    // Zero word at 40: halts with the option, issues as a normal word without it.
    redirect = 1'b1; redirect_addr = AW'(40); step();
    chk_outs("redir40", 16'hB203, 0, 40, 0);
    redirect = 1'b0; step();
    chk_outs("zero_word", HALT_EN ? 16'hB203 : 16'h0000, !HALT_EN, HALT_EN ? 40 : 41, HALT_EN);
    step();
    chk_outs("zero_next", HALT_EN ? 16'hB203 : pm[41], !HALT_EN, HALT_EN ? 40 : 42, HALT_EN);
    redirect = 1'b1; redirect_addr = '0; step();
    redirect = 1'b0;
    chk_outs("leave_halt", HALT_EN ? 16'hB203 : pm[41], 0, 0, 0);
    step(); chk_outs("restart0", 16'hB203, 1, 1, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 500; c++) begin
      instr_ready   = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 9) == 0);
      redirect_addr = ($urandom_range(0, 3) == 0) ? AW'(38) : AW'($urandom);
      step();
      chk_outs("rand", m_instr, m_valid, m_pc, m_halted);
      if (c == 250) begin
        #2 rst_n = 1'b0; model_reset();
        #1 chk_outs("rand_rst", m_instr, m_valid, m_pc, m_halted);
        @(negedge clk); rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
